// File: rtl/reg_file_32x64_pkg.sv
// Shared widths and types for the 32x64 register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_32x64_if.sv
// Read/write bus of the register file. The datapath is the master and the
// register file is the slave.
interface reg_file_32x64_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadSelect1;
    logic [ADDR_W-1:0] ReadSelect2;
    logic [ADDR_W-1:0] WriteSelect;
    logic [DATA_W-1:0] WriteData;
    logic              WriteEnable;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output ReadSelect1, ReadSelect2, WriteSelect, WriteData, WriteEnable,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadSelect1, ReadSelect2, WriteSelect, WriteData, WriteEnable,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/reg_file_32x64_read_port.sv
// One combinational read port: storage mux plus, when REGFILE_BYPASS_EN is
// defined, a same-cycle forward of the pending write data.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int P_DATA_W   = regfile_pkg::DATA_W,
    parameter int P_ADDR_W   = regfile_pkg::ADDR_W,
    parameter int P_NUM_REGS = 1 << P_ADDR_W
) (
    input  logic                rst,
    input  logic [P_DATA_W-1:0] regs [P_NUM_REGS],
    input  logic [P_ADDR_W-1:0] rd_sel,
    input  logic [P_ADDR_W-1:0] wr_sel,
    input  logic [P_DATA_W-1:0] wr_data,
    input  logic                wr_en,
    output logic [P_DATA_W-1:0] rd_data
);
`ifdef REGFILE_BYPASS_EN
    logic hit;

    // A reset cycle must not forward: the array is being cleared, not written.
    always_comb begin
        hit     = wr_en && !rst && (rd_sel == wr_sel);
        rd_data = hit ? wr_data : regs[rd_sel];
    end
`else
    logic unused_bypass;

    always_comb begin
        rd_data = regs[rd_sel];
    end

    assign unused_bypass = ^{rst, wr_sel, wr_data, wr_en};
`endif
endmodule

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one clocked write
// port, synchronous clear. REGFILE_BYPASS_EN adds write-through forwarding.
module reg_file_32x64
    import regfile_pkg::*;
#(
    parameter int P_DATA_W = regfile_pkg::DATA_W,
    parameter int P_ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_32x64_if.slave  bus
);
    localparam int P_NUM_REGS = 1 << P_ADDR_W;

    logic [P_DATA_W-1:0] regs_q [P_NUM_REGS];
    logic [P_DATA_W-1:0] regs_d [P_NUM_REGS];

    // Selects/data are only dereferenced under WriteEnable, so unknowns on an
    // idle write port leave the array untouched.
    always_comb begin
        regs_d = regs_q;
        if (bus.WriteEnable) begin
            regs_d[bus.WriteSelect] = bus.WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .P_DATA_W   (P_DATA_W),
        .P_ADDR_W   (P_ADDR_W),
        .P_NUM_REGS (P_NUM_REGS)
    ) u_rd1 (
        .rst     (rst),
        .regs    (regs_q),
        .rd_sel  (bus.ReadSelect1),
        .wr_sel  (bus.WriteSelect),
        .wr_data (bus.WriteData),
        .wr_en   (bus.WriteEnable),
        .rd_data (bus.ReadData1)
    );

    regfile_read_port #(
        .P_DATA_W   (P_DATA_W),
        .P_ADDR_W   (P_ADDR_W),
        .P_NUM_REGS (P_NUM_REGS)
    ) u_rd2 (
        .rst     (rst),
        .regs    (regs_q),
        .rd_sel  (bus.ReadSelect2),
        .wr_sel  (bus.WriteSelect),
        .wr_data (bus.WriteData),
        .wr_en   (bus.WriteEnable),
        .rd_data (bus.ReadData2)
    );
endmodule

// File: tb/tb_reg_file_32x64.sv
// Directed bench for reg_file_32x64; expected values are hand-computed constants.
module tb_reg_file_32x64;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    reg_file_32x64_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    reg_file_32x64 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] sel, input logic [63:0] data);
        bus.WriteSelect = sel;
        bus.WriteData   = data;
        bus.WriteEnable = 1'b1;
        tick();
        bus.WriteEnable = 1'b0;
    endtask

    initial begin
        bus.ReadSelect1 = '0;
        bus.ReadSelect2 = '0;
        bus.WriteSelect = '0;
        bus.WriteData   = '0;
        bus.WriteEnable = 1'b0;
        #2;

        // Clear and read every index through both ports.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.ReadSelect1 = 5'(i);
            bus.ReadSelect2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1[%0d]", i), bus.ReadData1, 64'd0);
            chk($sformatf("rst_rd2[%0d]", 31 - i), bus.ReadData2, 64'd0);
        end

        wr(5'd10, 64'd127);
        bus.ReadSelect2 = 5'd10;
        bus.ReadSelect1 = 5'd9;
        #1;
        chk("wr10_rd2", bus.ReadData2, 64'd127);
        chk("r9_clear", bus.ReadData1, 64'd0);

        wr(5'd9, 64'd32);
        #1;
        chk("wr9_rd1", bus.ReadData1, 64'd32);
        chk("r10_keep", bus.ReadData2, 64'd127);

        // Write port idle: nothing changes.
        bus.WriteSelect = 5'd10;
        bus.WriteData   = 64'd5;
        bus.WriteEnable = 1'b0;
        tick();
        chk("we0_keep", bus.ReadData2, 64'd127);

        // Unknown select/data with the write port idle.
        bus.WriteSelect = 'x;
        bus.WriteData   = 'x;
        tick();
        chk("x_keep9", bus.ReadData1, 64'd32);
        chk("x_keep10", bus.ReadData2, 64'd127);

        // Both ports on the same register.
        bus.ReadSelect1 = 5'd10;
        #1;
        chk("same_rd1", bus.ReadData1, 64'd127);
        chk("same_rd2", bus.ReadData2, 64'd127);

        // Edge indices, all-ones.
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(5'd0, 64'h1);
        bus.ReadSelect1 = 5'd31;
        bus.ReadSelect2 = 5'd0;
        #1;
        chk("r31_ones", bus.ReadData1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("r0_one", bus.ReadData2, 64'h1);

        // Reset beats a simultaneous write.
        rst = 1'b1;
        bus.WriteSelect = 5'd31;
        bus.WriteData   = 64'hDEAD_BEEF_0000_1234;
        bus.WriteEnable = 1'b1;
        tick();
        rst = 1'b0;
        bus.WriteEnable = 1'b0;
        chk("rstpri_r31", bus.ReadData1, 64'd0);
        chk("rstpri_r0", bus.ReadData2, 64'd0);
        bus.ReadSelect1 = 5'd10;
        #1;
        chk("rst_r10", bus.ReadData1, 64'd0);

        // Read-during-write on port 1; port 2 watches a different register.
        wr(5'd5, 64'h55);
        wr(5'd6, 64'h66);
        bus.ReadSelect1 = 5'd5;
        bus.ReadSelect2 = 5'd6;
        bus.WriteSelect = 5'd5;
        bus.WriteData   = 64'hAA;
        bus.WriteEnable = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rdw_pre", bus.ReadData1, 64'hAA);
`else
        chk("rdw_pre", bus.ReadData1, 64'h55);
`endif
        chk("rdw_other", bus.ReadData2, 64'h66);
        tick();
        bus.WriteEnable = 1'b0;
        #1;
        chk("rdw_post", bus.ReadData1, 64'hAA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
